// File: rtl/square_draw_datapath.sv
// rtl/square_draw_datapath.sv - 4x4 square sweep datapath with registered VGA pixel outputs
// Optional feature macro: SQUARE_ERASE_EN (adds erase input, sweep draws colour 0)
module square_draw_datapath #(
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOUR_W  = 3,
   parameter int SIDE_LOG2 = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [6:0]          data_in,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic                ld_x,
   input  logic                ld_y,
   input  logic                ld_colour,
   input  logic                start_draw,
`ifdef SQUARE_ERASE_EN
   input  logic                erase,
`endif
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot_out,
   output logic                busy,
   output logic                done
);

   localparam int OFS_W = 2 * SIDE_LOG2;
   localparam logic [OFS_W-1:0] OFS_LAST = '1;
   localparam logic [OFS_W-1:0] OFS_ONE  = 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [OFS_W-1:0]    offset_q, offset_d;
   logic [X_W-1:0]      x_base_q, x_base_d;
   logic [Y_W-1:0]      y_base_q, y_base_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] col_out_q, col_out_d;
   logic                plot_q, plot_d;
`ifdef SQUARE_ERASE_EN
   logic                erase_q, erase_d;
`endif

   logic [SIDE_LOG2-1:0] dx, dy;
   logic [X_W:0]         x_sum;
   logic [Y_W:0]         y_sum;
   logic                 clip;
   logic [COLOUR_W-1:0]  pix_colour;

   // One extra sum bit catches squares that run off the right or bottom edge.
   assign dx    = offset_q[SIDE_LOG2-1:0];
   assign dy    = offset_q[OFS_W-1:SIDE_LOG2];
   assign x_sum = {1'b0, x_base_q} + {{(X_W+1-SIDE_LOG2){1'b0}}, dx};
   assign y_sum = {1'b0, y_base_q} + {{(Y_W+1-SIDE_LOG2){1'b0}}, dy};
   assign clip  = x_sum[X_W] | y_sum[Y_W];

`ifdef SQUARE_ERASE_EN
   assign pix_colour = erase_q ? '0 : colour_q;
`else
   assign pix_colour = colour_q;
`endif

   always_comb begin
      state_d   = state_q;
      offset_d  = offset_q;
      x_base_d  = x_base_q;
      y_base_d  = y_base_q;
      colour_d  = colour_q;
      x_d       = x_q;
      y_d       = y_q;
      col_out_d = col_out_q;
      plot_d    = 1'b0;
`ifdef SQUARE_ERASE_EN
      erase_d   = erase_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ld_x)      x_base_d = X_W'(data_in);
            if (ld_y)      y_base_d = Y_W'(data_in);
            if (ld_colour) colour_d = colour_in;
            if (start_draw) begin
               state_d  = S_DRAW;
               offset_d = '0;
`ifdef SQUARE_ERASE_EN
               erase_d  = erase;
`endif
            end
         end
         S_DRAW: begin
            offset_d = offset_q + OFS_ONE;
            if (!clip) begin
               x_d       = x_sum[X_W-1:0];
               y_d       = y_sum[Y_W-1:0];
               col_out_d = pix_colour;
               plot_d    = 1'b1;
            end
            if (offset_q == OFS_LAST) state_d = S_DONE;
         end
         // Waiting for start_draw to drop keeps a held request from relaunching.
         S_DONE: begin
            if (!start_draw) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         offset_q  <= '0;
         x_base_q  <= '0;
         y_base_q  <= '0;
         colour_q  <= '0;
         x_q       <= '0;
         y_q       <= '0;
         col_out_q <= '0;
         plot_q    <= 1'b0;
`ifdef SQUARE_ERASE_EN
         erase_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         offset_q  <= offset_d;
         x_base_q  <= x_base_d;
         y_base_q  <= y_base_d;
         colour_q  <= colour_d;
         x_q       <= x_d;
         y_q       <= y_d;
         col_out_q <= col_out_d;
         plot_q    <= plot_d;
`ifdef SQUARE_ERASE_EN
         erase_q   <= erase_d;
`endif
      end
   end

   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = col_out_q;
   assign plot_out   = plot_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule
